// File: rtl/branch_cond_resolver.sv
// Condition-code consumer: holds NZCV flags, tracks in-flight flag writers
// and resolves branch conditions with a registered taken/not-taken result.
module branch_cond_resolver #(
  parameter int FLAG_W   = 4,
  parameter int COND_W   = 4,
  parameter int PEND_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              set_cond,
  input  logic              issue_setter,
  input  logic              br_valid,
  input  logic [COND_W-1:0] br_cond,
  output logic              br_ready,
  input  logic              flush,
  output logic              res_valid,
  output logic              res_taken,
  output logic [FLAG_W-1:0] cond_q,
  output logic [1:0]        pend_cnt,
  output logic              pend_ovf
);

  localparam logic [1:0] LP_PMAX = 2'(PEND_MAX);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            r_state;
  logic [COND_W-1:0] r_cond;
  logic [FLAG_W-1:0] r_flags;
  logic [1:0]        r_pend;
  logic              r_ovf;
  logic              r_res_valid;
  logic              r_res_taken;

  logic [FLAG_W-1:0] w_eff_flags;
  logic [1:0]        w_eff_pend;
  logic              w_accept;
  logic              w_release;

  function automatic logic f_decode(
    input logic [COND_W-1:0] c,
    input logic [FLAG_W-1:0] f
  );
    logic n, z, cy, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    unique case (c[3:0])
      4'h0: r = z;
      4'h1: r = !z;
      4'h2: r = cy;
      4'h3: r = !cy;
      4'h4: r = n;
      4'h5: r = !n;
      4'h6: r = v;
      4'h7: r = !v;
      4'h8: r = cy & !z;
      4'h9: r = !cy | z;
      4'hA: r = (n == v);
      4'hB: r = (n != v);
      4'hC: r = !z & (n == v);
      4'hD: r = z | (n != v);
      4'hE: r = 1'b1;
      4'hF: r = 1'b0;
    endcase
    return r;
  endfunction

  // A set_cond this cycle retires one older writer and forwards its flags.
  assign w_eff_flags = set_cond ? flags_in : r_flags;
  assign w_eff_pend  = (set_cond && r_pend != 2'd0) ?
                       r_pend - 2'd1 : r_pend;

  assign br_ready  = (r_state == IDLE) && !flush;
  assign w_accept  = br_valid && br_ready;
  assign w_release = (w_eff_pend == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cond      <= '1;
      r_flags     <= '0;
      r_pend      <= 2'd0;
      r_ovf       <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_taken <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (set_cond) r_flags <= flags_in;

      unique case ({issue_setter, set_cond})
        2'b10: begin
          if (r_pend == LP_PMAX) r_ovf <= 1'b1;
          else r_pend <= r_pend + 2'd1;
        end
        2'b01: begin
          if (r_pend != 2'd0) r_pend <= r_pend - 2'd1;
        end
        default: ;
      endcase

      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_release) begin
              r_res_valid <= 1'b1;
              r_res_taken <= f_decode(br_cond, w_eff_flags);
            end else begin
              r_cond  <= br_cond;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (flush) begin
            r_state <= IDLE;
          end else if (w_release) begin
            r_res_valid <= 1'b1;
            r_res_taken <= f_decode(r_cond, w_eff_flags);
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_taken = r_res_taken;
  assign cond_q    = r_flags;
  assign pend_cnt  = r_pend;
  assign pend_ovf  = r_ovf;

endmodule

// File: tb/tb_branch_cond_resolver.sv
// Directed bench for branch_cond_resolver; expected results are queued
// at drive time and popped by a monitor when res_valid pulses.
module tb_branch_cond_resolver;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] flags_in;
  logic       set_cond;
  logic       issue_setter;
  logic       br_valid;
  logic [3:0] br_cond;
  logic       br_ready;
  logic       flush;
  logic       res_valid;
  logic       res_taken;
  logic [3:0] cond_q;
  logic [1:0] pend_cnt;
  logic       pend_ovf;

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_q[$];
  logic [3:0] pats[5];

  branch_cond_resolver #(
    .FLAG_W(4), .COND_W(4), .PEND_MAX(3)
  ) dut (
    .clk(clk), .rst(rst),
    .flags_in(flags_in), .set_cond(set_cond),
    .issue_setter(issue_setter),
    .br_valid(br_valid), .br_cond(br_cond),
    .br_ready(br_ready), .flush(flush),
    .res_valid(res_valid), .res_taken(res_taken),
    .cond_q(cond_q), .pend_cnt(pend_cnt),
    .pend_ovf(pend_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_res_valid", 1, 0);
      end else begin
        chk("res_taken", int'(res_taken), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic [3:0] c, input logic [3:0] f);
    br_valid = 1'b1;
    br_cond  = c;
    exp_q.push_back(model(c, f));
    step();
    br_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flags_in = '0; set_cond = 0; issue_setter = 0;
    br_valid = 0; br_cond = '0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cond_q", cond_q, 0);
    chk("rst_pend_cnt", pend_cnt, 0);
    chk("rst_pend_ovf", pend_ovf, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_taken", res_taken, 0);
    rst = 1'b0;
    step();

    br_valid = 1; br_cond = 4'hE;
    #1 chk("ready_idle", br_ready, 1);
    exp_q.push_back(1'b1);
    step();
    br_cond = 4'hF;
    exp_q.push_back(1'b0);
    step();
    br_valid = 0;
    step();

    set_cond = 1; flags_in = 4'b0100;
    step();
    set_cond = 0;
    chk("cond_q_z", cond_q, 4'b0100);
    branch(4'h0, 4'b0100);
    branch(4'h1, 4'b0100);
    branch(4'hC, 4'b0100);
    step();
    chk("res_taken_hold", res_taken, 0);

    issue_setter = 1;
    step();
    issue_setter = 0;
    chk("pend_one", pend_cnt, 1);
    br_valid = 1; br_cond = 4'hA;
    step();
    br_valid = 0;
    #1 chk("ready_wait", br_ready, 0);
    step();
    step();
    set_cond = 1; flags_in = 4'b1001;
    exp_q.push_back(1'b1);
    step();
    set_cond = 0;
    chk("ready_after_release", br_ready, 1);
    chk("pend_after_release", pend_cnt, 0);
    step();

    issue_setter = 1;
    step();
    issue_setter = 0;
    br_valid = 1; br_cond = 4'h2;
    set_cond = 1; flags_in = 4'b0010;
    #1 chk("ready_forward", br_ready, 1);
    exp_q.push_back(1'b1);
    step();
    br_valid = 0; set_cond = 0;
    chk("pend_forward", pend_cnt, 0);
    step();

    issue_setter = 1;
    repeat (4) step();
    issue_setter = 0;
    chk("pend_sat", pend_cnt, 3);
    chk("pend_ovf_set", pend_ovf, 1);
    issue_setter = 1; set_cond = 1; flags_in = 4'b0000;
    step();
    issue_setter = 0;
    chk("pend_both", pend_cnt, 3);
    repeat (3) step();
    chk("pend_drain", pend_cnt, 0);
    step();
    set_cond = 0;
    chk("pend_floor", pend_cnt, 0);
    chk("ovf_sticky", pend_ovf, 1);

    pats[0] = 4'b0000; pats[1] = 4'b0100; pats[2] = 4'b1001;
    pats[3] = 4'b0010; pats[4] = 4'b1010;
    for (int p = 0; p < 5; p++) begin
      set_cond = 1; flags_in = pats[p];
      step();
      set_cond = 0;
      for (int c = 0; c < 16; c++) branch(4'(c), pats[p]);
    end
    step();

    issue_setter = 1;
    step();
    issue_setter = 0;
    br_valid = 1; br_cond = 4'h0;
    step();
    br_valid = 0;
    step();
    set_cond = 1; flags_in = 4'b0100; flush = 1;
    step();
    set_cond = 0; flush = 0;
    repeat (3) step();
    chk("flush_idle", br_ready, 1);
    chk("flush_cond_q", cond_q, 4'b0100);
    chk("flush_pend", pend_cnt, 0);

    br_valid = 1; br_cond = 4'hE; flush = 1;
    #1 chk("flush_blocks_ready", br_ready, 0);
    step();
    br_valid = 0; flush = 0;
    step();

    issue_setter = 1;
    step();
    issue_setter = 0;
    br_valid = 1; br_cond = 4'hE;
    step();
    br_valid = 0;
    #2 rst = 1;
    #1;
    chk("rstw_cond_q", cond_q, 0);
    chk("rstw_pend", pend_cnt, 0);
    chk("rstw_ovf", pend_ovf, 0);
    chk("rstw_res_valid", res_valid, 0);
    chk("rstw_res_taken", res_taken, 0);
    chk("rstw_ready", br_ready, 1);
    step();
    rst = 0;
    repeat (3) step();
    chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_cond_resolver.md
Name: branch_cond_resolver

Overview:
- Consumer side of the condition-code path. Holds the NZCV flags written by the execute stage (ALU flag output plus set_cond strobe).
- Tracks flag-setting instructions still in flight and evaluates 4-bit branch condition fields against the current flags.
- Returns a registered taken/not-taken result to fetch/decode.
- Stalls a branch through a valid/ready handshake until all older flag writers have retired.

Parameters:
- FLAG_W, 4, flag width; bit3 N, bit2 Z, bit1 C, bit0 V.
- COND_W, 4, branch condition field width.
- PEND_MAX, 3, maximum outstanding flag-setting instructions tracked.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- flags_in  in  FLAG_W  ALU flag output (NZCV)
- set_cond  in  1  flags_in valid this cycle; latch it
- issue_setter  in  1  flag-setting instruction issued to execute this cycle
- br_valid  in  1  branch request present
- br_cond  in  COND_W  branch condition code
- br_ready  out  1  resolver can accept a branch
- flush  in  1  discard a waiting branch
- res_valid  out  1  one-cycle result strobe
- res_taken  out  1  condition true; qualified by res_valid
- cond_q  out  FLAG_W  architectural flag register
- pend_cnt  out  2  outstanding flag writers
- pend_ovf  out  1  sticky error: issue_setter while pend_cnt==PEND_MAX

Behaviour:
- Reset (async, rst=1):
  - cond_q=4'b0000, pend_cnt=0, pend_ovf=0, res_valid=0, res_taken=0.
  - State=IDLE, captured condition=4'b1111.
- Flag register: on each clk with set_cond=1, cond_q<=flags_in. No other write path.
- Pending counter:
  - issue_setter alone: +1.
  - set_cond alone: -1.
  - Both in the same cycle: unchanged.
  - set_cond at 0: stays 0; flags are still latched.
  - issue_setter at PEND_MAX: count holds and pend_ovf<=1 (cleared only by rst).
- Forwarding:
  - eff_flags = set_cond ? flags_in : cond_q.
  - eff_pend = pend_cnt - set_cond, saturating at 0.
  - issue_setter in the same cycle as a branch accept is younger than the branch and is ignored for that branch.
- Condition decode (cond -> taken):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F NV: 0
- FSM states: IDLE, WAIT.
  - br_ready = (state==IDLE). Accept = br_valid & br_ready.
  - IDLE, accept with eff_pend==0: next cycle res_valid=1, res_taken=decode(br_cond, eff_flags). Stay IDLE. Back-to-back accepts give one result per cycle.
  - IDLE, accept with eff_pend!=0: capture br_cond, go WAIT, no result.
  - WAIT, eff_pend==0: next cycle res_valid=1, res_taken=decode(captured, eff_flags), go IDLE.
  - WAIT, eff_pend!=0: hold.
- Latency: 1 cycle from accept (or from the final releasing set_cond) to res_valid.
- res_valid is a single-cycle pulse. res_taken holds its last value when res_valid=0.
- flush:
  - In WAIT: go IDLE next cycle, no result produced.
  - flush and release in the same cycle: flush wins.
  - In IDLE: flush blocks the accept (br_ready is forced low that cycle).
  - flush never alters cond_q or pend_cnt.
- rst mid-WAIT: branch dropped, no result, all outputs at reset values.

Test Plan:
- Reset, then br_cond=4'hE, br_valid=1 with pend_cnt=0 -> br_ready=1; next cycle res_valid=1, res_taken=1. Repeat with 4'hF -> res_taken=0.
- set_cond=1, flags_in=4'b0100 (Z); next cycle branch 4'h0 -> res_taken=1; branch 4'h1 -> res_taken=0; branch 4'hC -> res_taken=0.
- issue_setter pulse (pend_cnt=1), then branch 4'hA -> state WAIT, br_ready=0. Three cycles later set_cond with flags_in=4'b1001 (N=V=1) -> res_valid=1, res_taken=1 one cycle later; br_ready=1 again.
- pend_cnt=1, branch 4'h2 in the same cycle as set_cond with flags_in=4'b0010 -> forwarded: accepted immediately, res_taken=1 next cycle.
- Four issue_setter pulses with no set_cond -> pend_cnt=3, pend_ovf=1. Simultaneous issue_setter+set_cond -> pend_cnt unchanged.
- Branch stalled in WAIT, then flush and set_cond together -> no res_valid in the following 3 cycles, state IDLE, cond_q updated. Also assert rst mid-WAIT -> all outputs at reset values immediately.
